// File: rtl/gshare_branch_predictor.sv
// Global-history branch predictor: PHT indexed by GHR (MODE=0) or GHR^PC (MODE=1, gshare).
// The PHT is filled by a sweep after reset; prediction and update are independent ports.
module gshare_branch_predictor #(
   parameter int GHR_W  = 3,
   parameter int CNT_W  = 2,
   parameter int PC_W   = 8,
   parameter int MODE   = 0,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ready,
   input  logic              pred_req,
   input  logic [PC_W-1:0]   pred_pc,
   output logic              pred_ack,
   output logic              pred_taken,
   output logic [CNT_W-1:0]  pred_cnt,
   output logic [GHR_W-1:0]  pred_index,
   input  logic              upd_en,
   input  logic [GHR_W-1:0]  upd_index,
   input  logic              upd_taken,
   input  logic              upd_pred,
   output logic [GHR_W-1:0]  ghr_out,
   output logic [STAT_W-1:0] total_cnt,
   output logic [STAT_W-1:0] correct_cnt
);

   localparam int               DEPTH    = 2 ** GHR_W;
   localparam logic [CNT_W-1:0] CNT_WNT  = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [GHR_W-1:0] PTR_LAST = GHR_W'(DEPTH - 1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic taken);
      logic [CNT_W-1:0] r;
      if (taken) begin
         r = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
      end else begin
         r = (c == {CNT_W{1'b0}}) ? c : c - CNT_W'(1);
      end
      return r;
   endfunction

   function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

   state_e             state_q;
   logic [GHR_W-1:0]   ptr_q;
   logic [CNT_W-1:0]   pht_q [DEPTH];
   logic [GHR_W-1:0]   ghr_q;
   logic [STAT_W-1:0]  total_q;
   logic [STAT_W-1:0]  correct_q;
   logic               ack_q;
   logic               taken_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [GHR_W-1:0]   idx_q;

   logic               run_s;
   logic [GHR_W-1:0]   pred_idx_s;
   logic               wr_en_s;
   logic [GHR_W-1:0]   wr_addr_s;
   logic [CNT_W-1:0]   wr_data_s;
   logic               unused_pc_s;

   assign unused_pc_s = ^pred_pc;
   assign run_s       = (state_q == ST_RUN);

   // Index for the current request, formed from the pre-update history.
   always_comb begin
      pred_idx_s = ghr_q;
      if (MODE != 0) begin
         pred_idx_s = ghr_q ^ pred_pc[GHR_W-1:0];
      end else begin
         pred_idx_s = ghr_q;
      end
   end

   // Single PHT write port: the init sweep owns it until the FSM reaches RUN.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = ptr_q;
      wr_data_s = CNT_WNT;
      if (state_q == ST_INIT) begin
         wr_en_s = 1'b1;
      end else if (upd_en) begin
         wr_en_s   = 1'b1;
         wr_addr_s = upd_index;
         wr_data_s = cnt_step(pht_q[upd_index], upd_taken);
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Pattern history table storage; no reset, the sweep initialises it.
   always_ff @(posedge clk) begin
      if (!reset && wr_en_s) begin
         pht_q[wr_addr_s] <= wr_data_s;
      end
   end

   // Init/run FSM with registered prediction outputs, history and statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_INIT;
         ptr_q     <= '0;
         ghr_q     <= '0;
         total_q   <= '0;
         correct_q <= '0;
         ack_q     <= 1'b0;
         taken_q   <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               ack_q <= 1'b0;
               ptr_q <= ptr_q + GHR_W'(1);
               if (ptr_q == PTR_LAST) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               ack_q <= pred_req;
               if (pred_req) begin
                  idx_q   <= pred_idx_s;
                  cnt_q   <= pht_q[pred_idx_s];
                  taken_q <= pht_q[pred_idx_s][CNT_W-1];
               end
               if (upd_en) begin
                  ghr_q   <= GHR_W'({ghr_q, upd_taken});
                  total_q <= stat_inc(total_q);
                  if (upd_pred == upd_taken) begin
                     correct_q <= stat_inc(correct_q);
                  end
               end
            end
            default: begin
               state_q <= ST_INIT;
               ptr_q   <= '0;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ready       = run_s;
   assign pred_ack    = ack_q;
   assign pred_taken  = taken_q;
   assign pred_cnt    = cnt_q;
   assign pred_index  = idx_q;
   assign ghr_out     = ghr_q;
   assign total_cnt   = total_q;
   assign correct_cnt = correct_q;

endmodule
